// File: rtl/bin2bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// Optional leading-zero blanking is enabled by BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= ADD3_THRESH) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Leading-zero blank mask generated only when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf,
  output logic [DIGITS-1:0]             blank
);

  localparam int BW    = BCD_DIGIT_W * DIGITS;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int CAT_W = BW + WIDTH;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    scr_q, scr_d;
  logic             oscr_q, oscr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  logic [BW-1:0]    adj;
  logic [CAT_W-1:0] cat;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    oscr_d  = oscr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cat     = {adj, sr_q} << 1;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = '0;
          oscr_d  = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        scr_d  = cat[CAT_W-1:WIDTH];
        sr_d   = cat[WIDTH-1:0];
        // bit pushed out of the top digit means value >= 10^DIGITS
        oscr_d = oscr_q | adj[BW-1];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_d;
          ovf_d   = oscr_d;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      oscr_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      oscr_q  <= oscr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_calc;
  logic              zero;
  logic              load;

  always_comb begin
    load       = (state_q == S_SHIFT) && (cnt_q == CW'(1));
    blank_calc = '0;
    zero       = 1'b1;
    // scan from the top digit down; units digit is never blanked
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero          = zero & (bcd_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_calc[i] = zero & ~ovf_d;
    end
    blank_d = load ? blank_calc : blank_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= BLANK_RST;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic model.
// Honours BIN2BCD_BLANK_EN when computing the expected blank mask.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        ovf;
  logic [2:0]  blank;

  logic        start2;
  logic [7:0]  bin2;
  logic        busy2;
  logic        done2;
  logic [7:0]  bcd2;
  logic        ovf2;
  logic [1:0]  blank2;

  int errors;
  int checks;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf),
    .blank (blank)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .bin   (bin2),
    .busy  (busy2),
    .done  (done2),
    .bcd   (bcd2),
    .ovf   (ovf2),
    .blank (blank2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ndig(input int v);
    int n;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] m_bcd(input int v, input int d);
    logic [11:0] r;
    int          x;
    r = '0;
    x = v % pow10(d);
    for (int i = 0; i < d; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] m_blank(input int v, input int d);
    logic [2:0] r;
    r = '0;
`ifdef BIN2BCD_BLANK_EN
    if (v < pow10(d))
      for (int i = 1; i < d; i++) r[i] = (i >= ndig(v));
`endif
    return r;
  endfunction

  function automatic logic [2:0] m_blank_rst(input int d);
    logic [2:0] r;
    r = '0;
`ifdef BIN2BCD_BLANK_EN
    for (int i = 1; i < d; i++) r[i] = 1'b1;
`endif
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_conv(input int v, output int lat, output int bcnt,
                         output logic changed, output logic both);
    logic [11:0] prev;
    @(negedge clk);
    bin     = v[7:0];
    start   = 1'b1;
    prev    = bcd;
    changed = 1'b0;
    both    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'($urandom);
    bcnt  = busy ? 1 : 0;
    lat   = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (busy && done) both = 1'b1;
      if (!done && bcd !== prev) changed = 1'b1;
    end while (!done && lat < 40);
  endtask

  task automatic do_conv2(input int v, output int lat);
    @(negedge clk);
    bin2   = v[7:0];
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat    = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done2 && lat < 40);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (bcd !== 12'h000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_data bcd=%h ovf=%b required 000 0", bcd, ovf);
    end
    checks++;
    if (blank !== m_blank_rst(3)) begin
      errors++;
      $display("FAIL reset_blank got=%b required=%b", blank, m_blank_rst(3));
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b bcd=%h", busy, done, bcd);
    end
  endtask

  task automatic test_known;
    int          vals[4];
    int          lat, bcnt;
    logic        ch, both;
    vals = '{255, 0, 7, 40};
    foreach (vals[k]) begin
      do_conv(vals[k], lat, bcnt, ch, both);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL known_latency v=%0d got=%0d required=8", vals[k], lat);
      end
      checks++;
      if (bcd !== m_bcd(vals[k], 3) || ovf !== 1'b0) begin
        errors++;
        $display("FAIL known_bcd v=%0d got=%h/%b required=%h/0",
                 vals[k], bcd, ovf, m_bcd(vals[k], 3));
      end
      checks++;
      if (blank !== m_blank(vals[k], 3)) begin
        errors++;
        $display("FAIL known_blank v=%0d got=%b required=%b",
                 vals[k], blank, m_blank(vals[k], 3));
      end
    end
  endtask

  task automatic test_back_to_back;
    int   lat, bcnt, gap, extra;
    logic ch, both;
    do_conv(99, lat, bcnt, ch, both);
    bin   = 8'd100;
    start = 1'b1;
    checks++;
    if (bcd !== 12'h099) begin
      errors++;
      $display("FAIL b2b_first got=%h required=099", bcd);
    end
    @(negedge clk);
    start = 1'b0;
    gap   = 1;
    while (!done && gap < 40) begin
      @(negedge clk);
      gap++;
      start = (gap == 3 || gap == 5);
      bin   = 8'd5;
    end
    start = 1'b0;
    checks++;
    if (gap !== 9) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d required=9", gap);
    end
    checks++;
    if (bcd !== 12'h100) begin
      errors++;
      $display("FAIL b2b_second got=%h required=100", bcd);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL b2b_extra_done got=%0d required=0", extra);
    end
  endtask

  task automatic test_rst_abort;
    int   lat, bcnt, dn;
    logic ch, both;
    @(negedge clk);
    bin   = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || ovf !== 1'b0 ||
        blank !== m_blank_rst(3)) begin
      errors++;
      $display("FAIL abort_outputs busy=%b done=%b bcd=%h ovf=%b blank=%b",
               busy, done, bcd, ovf, blank);
    end
    @(negedge clk);
    rst = 1'b0;
    dn  = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d required=0", dn);
    end
    do_conv(200, lat, bcnt, ch, both);
    checks++;
    if (bcd !== 12'h200 || lat !== 8) begin
      errors++;
      $display("FAIL abort_redo bcd=%h lat=%0d required=200 8", bcd, lat);
    end
  endtask

  task automatic test_ovf;
    int lat;
    do_conv2(123, lat);
    checks++;
    if (lat !== 8 || bcd2 !== 8'h23 || ovf2 !== 1'b1 || blank2 !== 2'b00) begin
      errors++;
      $display("FAIL ovf_123 lat=%0d bcd=%h ovf=%b blank=%b required 8 23 1 00",
               lat, bcd2, ovf2, blank2);
    end
    do_conv2(45, lat);
    checks++;
    if (bcd2 !== 8'h45 || ovf2 !== 1'b0 || blank2 !== m_blank(45, 2)) begin
      errors++;
      $display("FAIL ovf_45 bcd=%h ovf=%b blank=%b required 45 0 %b",
               bcd2, ovf2, blank2, m_blank(45, 2));
    end
    for (int k = 0; k < 12; k++) begin
      int v;
      v = $urandom_range(0, 255);
      do_conv2(v, lat);
      checks++;
      if (bcd2 !== m_bcd(v, 2)[7:0] || ovf2 !== (v >= 100) ||
          blank2 !== m_blank(v, 2)[1:0]) begin
        errors++;
        $display("FAIL ovf_rand v=%0d bcd=%h ovf=%b blank=%b", v, bcd2, ovf2, blank2);
      end
    end
  endtask

  task automatic test_sweep;
    int          lat, bcnt;
    logic        ch, both, bad_nib;
    for (int v = 0; v < 256; v++) begin
      do_conv(v, lat, bcnt, ch, both);
      bad_nib = 1'b0;
      for (int i = 0; i < 3; i++)
        if (bcd[i*4 +: 4] > 4'd9) bad_nib = 1'b1;
      checks++;
      if (bcd !== m_bcd(v, 3) || ovf !== 1'b0 || bad_nib) begin
        errors++;
        $display("FAIL sweep_bcd v=%0d got=%h ovf=%b required=%h", v, bcd, ovf, m_bcd(v, 3));
      end
      checks++;
      if (blank !== m_blank(v, 3)) begin
        errors++;
        $display("FAIL sweep_blank v=%0d got=%b required=%b", v, blank, m_blank(v, 3));
      end
      checks++;
      if (lat !== 8 || bcnt !== 8 || both || ch) begin
        errors++;
        $display("FAIL sweep_timing v=%0d lat=%0d busy_cycles=%0d both=%b early_change=%b",
                 v, lat, bcnt, both, ch);
      end
    end
  endtask

  task automatic test_random_gaps;
    int   lat, bcnt, v;
    logic ch, both;
    for (int k = 0; k < 40; k++) begin
      v = $urandom_range(0, 255);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_conv(v, lat, bcnt, ch, both);
      checks++;
      if (bcd !== m_bcd(v, 3) || blank !== m_blank(v, 3) || lat !== 8 || ch) begin
        errors++;
        $display("FAIL random v=%0d bcd=%h blank=%b lat=%0d required=%h %b 8",
                 v, bcd, blank, lat, m_bcd(v, 3), m_blank(v, 3));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bin    = '0;
    start2 = 1'b0;
    bin2   = '0;
    test_reset;
    test_known;
    test_back_to_back;
    test_rst_abort;
    test_ovf;
    test_sweep;
    test_random_gaps;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
